crypto_sched: RTL

CRYPTO_SCHED -- requirements
Module: crypto_sched

---
 rtl/crypto_sched.sv | 129 ++++++++++++
 1 files changed

// File: rtl/crypto_sched.sv
`default_nettype none
// ============================================================================
// crypto_sched : two-requester arbiter and sequencer for a shared block core
// Revision     : 1.0
// ============================================================================
module crypto_sched #(
  parameter int DW      = 128,
  parameter int TIMEOUT = 1023
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_i,
  input  logic          req0_valid,
  input  logic          req1_valid,
  output logic          req0_ready,
  output logic          req1_ready,
  input  logic [DW-1:0] req0_data,
  input  logic [DW-1:0] req1_data,
  input  logic          req0_mode,
  input  logic          req1_mode,
  output logic          rsp0_valid,
  output logic          rsp1_valid,
  input  logic          rsp0_ready,
  input  logic          rsp1_ready,
  output logic [DW-1:0] rsp0_data,
  output logic [DW-1:0] rsp1_data,
  output logic          rsp0_err,
  output logic          rsp1_err,
  output logic          core_start,
  output logic          core_mode,
  output logic [DW-1:0] core_din,
  input  logic          core_done,
  input  logic [DW-1:0] core_dout
);

  localparam logic [1:0]  c_IDLE    = 2'd0;
  localparam logic [1:0]  c_ISSUE   = 2'd1;
  localparam logic [1:0]  c_WAIT    = 2'd2;
  localparam logic [1:0]  c_RESP    = 2'd3;
  localparam logic [15:0] c_TIMEOUT = 16'(TIMEOUT);

  logic [1:0]    r_state;
  logic          r_ptr;
  logic          r_owner;
  logic [15:0]   r_cnt;
  logic [DW-1:0] r_data;
  logic          r_mode;
  logic [DW-1:0] r_result;
  logic          r_err;

  logic          w_grant;
  logic          w_idle;
  logic          w_accept;
  logic          w_resp;
  logic          w_rsp_hs;
  logic [15:0]   w_cnt_next;

  // Ready is gated by reset so nothing is offered while the block is held.
  assign w_grant    = (req0_valid && req1_valid) ? r_ptr : req1_valid;
  assign w_idle     = (r_state == c_IDLE) && !wb_rst_i;
  assign req0_ready = w_idle && !w_grant && req0_valid;
  assign req1_ready = w_idle &&  w_grant && req1_valid;
  assign w_accept   = req0_ready || req1_ready;

  assign w_resp     = (r_state == c_RESP);
  assign rsp0_valid = w_resp && !r_owner;
  assign rsp1_valid = w_resp &&  r_owner;
  assign rsp0_data  = rsp0_valid ? r_result : '0;
  assign rsp1_data  = rsp1_valid ? r_result : '0;
  assign rsp0_err   = rsp0_valid && r_err;
  assign rsp1_err   = rsp1_valid && r_err;
  assign w_rsp_hs   = (rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready);

  assign core_start = (r_state == c_ISSUE);
  assign core_din   = r_data;
  assign core_mode  = r_mode;

  // Count includes the current WAIT cycle, so WAIT lasts at most TIMEOUT cycles.
  assign w_cnt_next = r_cnt + 16'd1;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state  <= c_IDLE;
      r_ptr    <= 1'b0;
      r_owner  <= 1'b0;
      r_cnt    <= '0;
      r_data   <= '0;
      r_mode   <= 1'b0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_accept) begin
            r_data  <= w_grant ? req1_data : req0_data;
            r_mode  <= w_grant ? req1_mode : req0_mode;
            r_owner <= w_grant;
            r_state <= c_ISSUE;
          end
        end
        c_ISSUE: begin
          r_cnt   <= '0;
          r_state <= c_WAIT;
        end
        c_WAIT: begin
          if (core_done) begin
            r_result <= core_dout;
            r_err    <= 1'b0;
            r_state  <= c_RESP;
          end else if (w_cnt_next == c_TIMEOUT) begin
            r_result <= '0;
            r_err    <= 1'b1;
            r_state  <= c_RESP;
          end else begin
            r_cnt <= w_cnt_next;
          end
        end
        c_RESP: begin
          if (w_rsp_hs) begin
            r_ptr   <= !r_owner;
            r_state <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
